// File: rtl/axis_byte_checker.sv
// AXI-Stream byte sink for the demo generators: programmable backpressure,
// alternating 0x00/0x01 pattern check, beat/error statistics and stall timeout.

module axis_byte_checker #(
   parameter int unsigned READY_DELAY = 0,
   parameter int unsigned TIMEOUT     = 200000000
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        clear,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [7:0]  s_axis_tdata,
   output logic [15:0] beat_count,
   output logic [7:0]  err_count,
   output logic        error,
   output logic        timeout,
   output logic [31:0] last_interval
);

   localparam logic [1:0] ST_SYNC = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_OPEN = 2'd2;

   localparam int unsigned   DW        = (READY_DELAY > 32'd1) ? $clog2(READY_DELAY) : 1;
   localparam logic [DW-1:0] DLY_LOAD  = DW'((READY_DELAY > 32'd0) ? (READY_DELAY - 32'd1) : 32'd0);
   localparam logic [31:0]   TIMEOUT_C = 32'(TIMEOUT);

   logic [1:0]    state_r;
   logic          ready_r;
   logic [DW-1:0] delay_cnt_r;
   logic [31:0]   interval_r;
   logic          timeout_r;

   // Accepted beat, held for one cycle so statistics update on the following edge
   logic          acc_p_r;
   logic          acc_sync_r;
   logic [7:0]    acc_data_r;
   logic [31:0]   acc_int_r;

   logic [7:0]    ref_r;
   logic [15:0]   beat_count_r;
   logic [7:0]    err_count_r;
   logic          error_r;
   logic [31:0]   last_interval_r;

   logic          accept_s;
   logic          pattern_err_s;

   assign accept_s = s_axis_tvalid & ready_r;

   // Handshake, hold timing, interval measurement and stall detection
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r     <= ST_SYNC;
         ready_r     <= 1'b0;
         delay_cnt_r <= {DW{1'b0}};
         interval_r  <= 32'd1;
         timeout_r   <= 1'b0;
         acc_p_r     <= 1'b0;
         acc_sync_r  <= 1'b0;
         acc_data_r  <= 8'd0;
         acc_int_r   <= 32'd0;
      end else if (clear) begin
         state_r     <= ST_SYNC;
         ready_r     <= 1'b1;
         delay_cnt_r <= {DW{1'b0}};
         interval_r  <= 32'd1;
         timeout_r   <= 1'b0;
         acc_p_r     <= 1'b0;
         acc_sync_r  <= 1'b0;
         acc_data_r  <= 8'd0;
         acc_int_r   <= 32'd0;
      end else if (accept_s) begin
         acc_p_r    <= 1'b1;
         acc_sync_r <= (state_r == ST_SYNC);
         acc_data_r <= s_axis_tdata;
         acc_int_r  <= interval_r;
         interval_r <= 32'd1;
         timeout_r  <= 1'b0;
         if (READY_DELAY > 32'd0) begin
            state_r     <= ST_HOLD;
            ready_r     <= 1'b0;
            delay_cnt_r <= DLY_LOAD;
         end else begin
            state_r     <= ST_OPEN;
            ready_r     <= 1'b1;
            delay_cnt_r <= {DW{1'b0}};
         end
      end else begin
         acc_p_r <= 1'b0;
         if (interval_r != 32'hFFFF_FFFF) begin
            interval_r <= interval_r + 32'd1;
         end else begin
            interval_r <= interval_r;
         end
         // Counter saturates, so once past the threshold the flag stays up until a beat
         if (interval_r >= TIMEOUT_C) begin
            timeout_r <= 1'b1;
         end else begin
            timeout_r <= timeout_r;
         end
         case (state_r)
            ST_SYNC: ready_r <= 1'b1;
            ST_HOLD: begin
               if (delay_cnt_r == {DW{1'b0}}) begin
                  ready_r <= 1'b1;
                  state_r <= ST_OPEN;
               end else begin
                  delay_cnt_r <= delay_cnt_r - {{(DW-1){1'b0}}, 1'b1};
               end
            end
            ST_OPEN: ready_r <= 1'b1;
            default: begin
               state_r <= ST_SYNC;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   // The SYNC beat only fails on a non-zero upper nibble; later beats must toggle bit 0
   always_comb begin
      pattern_err_s = 1'b0;
      if (acc_sync_r) begin
         pattern_err_s = (acc_data_r[7:4] != 4'h0);
      end else begin
         pattern_err_s = (acc_data_r != {7'b0000000, ~ref_r[0]});
      end
   end

   // Beat statistics, one edge behind the accepting edge
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ref_r           <= 8'd0;
         beat_count_r    <= 16'd0;
         err_count_r     <= 8'd0;
         error_r         <= 1'b0;
         last_interval_r <= 32'd0;
      end else if (clear) begin
         ref_r           <= 8'd0;
         beat_count_r    <= 16'd0;
         err_count_r     <= 8'd0;
         error_r         <= 1'b0;
         last_interval_r <= 32'd0;
      end else if (acc_p_r) begin
         ref_r        <= acc_data_r;
         beat_count_r <= beat_count_r + 16'd1;
         if (!acc_sync_r) begin
            last_interval_r <= acc_int_r;
         end else begin
            last_interval_r <= last_interval_r;
         end
         if (pattern_err_s) begin
            error_r <= 1'b1;
            if (err_count_r != 8'hFF) begin
               err_count_r <= err_count_r + 8'd1;
            end else begin
               err_count_r <= err_count_r;
            end
         end else begin
            error_r     <= error_r;
            err_count_r <= err_count_r;
         end
      end else begin
         ref_r           <= ref_r;
         beat_count_r    <= beat_count_r;
         err_count_r     <= err_count_r;
         error_r         <= error_r;
         last_interval_r <= last_interval_r;
      end
   end

   assign s_axis_tready = ready_r;
   assign beat_count    = beat_count_r;
   assign err_count     = err_count_r;
   assign error         = error_r;
   assign timeout       = timeout_r;
   assign last_interval = last_interval_r;

   axis_byte_checker_chk u_chk (
      .aclk    (aclk),
      .aresetn (aresetn),
      .hold    (state_r == ST_HOLD),
      .ready   (ready_r),
      .error   (error_r),
      .err_nz  (err_count_r != 8'd0)
   );

endmodule

// Structural invariants of the checker: no ready while holding, and the sticky
// error flag always agrees with a non-zero error count.
module axis_byte_checker_chk (
   input logic aclk,
   input logic aresetn,
   input logic hold,
   input logic ready,
   input logic error,
   input logic err_nz
);

   a_hold_not_ready: assert property (@(posedge aclk) disable iff (!aresetn) hold |-> !ready);
   a_error_matches:  assert property (@(posedge aclk) disable iff (!aresetn) error == err_nz);

endmodule

// File: tb/tb_axis_byte_checker.sv
// Scoreboard bench: two checker instances (READY_DELAY 0 and 3, TIMEOUT 10) fed
// directed byte streams; a monitor pops expected statistics after each counted beat.

module tb_axis_byte_checker;

   typedef struct packed {
      logic [15:0] bc;
      logic [7:0]  ec;
      logic        er;
      logic [31:0] li;
   } exp_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;

   logic        v0 = 1'b0, clr0 = 1'b0, r0, er0, to0;
   logic [7:0]  dat0 = 8'd0, ec0;
   logic [15:0] bc0;
   logic [31:0] li0;

   logic        v3 = 1'b0, clr3 = 1'b0, r3, er3, to3;
   logic [7:0]  dat3 = 8'd0, ec3;
   logic [15:0] bc3;
   logic [31:0] li3;

   int checks = 0;
   int failures = 0;

   exp_t q0[$];
   exp_t q3[$];
   exp_t m0, m3;
   logic a0_d, a0_d1, a3_d, a3_d1;
   int   lows;

   always #5 aclk = ~aclk;

   axis_byte_checker #(.READY_DELAY(0), .TIMEOUT(10)) dut0 (
      .aclk(aclk), .aresetn(aresetn), .clear(clr0),
      .s_axis_tvalid(v0), .s_axis_tready(r0), .s_axis_tdata(dat0),
      .beat_count(bc0), .err_count(ec0), .error(er0), .timeout(to0), .last_interval(li0)
   );

   axis_byte_checker #(.READY_DELAY(3), .TIMEOUT(10)) dut3 (
      .aclk(aclk), .aresetn(aresetn), .clear(clr3),
      .s_axis_tvalid(v3), .s_axis_tready(r3), .s_axis_tdata(dat3),
      .beat_count(bc3), .err_count(ec3), .error(er3), .timeout(to3), .last_interval(li3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input int bc, input int ec, input logic er, input int li);
      exp_t e;
      e.bc = 16'(bc);
      e.ec = 8'(ec);
      e.er = er;
      e.li = 32'(li);
      return e;
   endfunction

   // Drive one beat from a negedge; returns at the negedge after the accepting edge
   task automatic send(input int u, input logic [7:0] d, input logic c, input logic push,
                       input exp_t e, output int n);
      n = 0;
      if (u == 0) begin v0 = 1'b1; dat0 = d; clr0 = c; end
      else begin v3 = 1'b1; dat3 = d; clr3 = c; end
      if (push) begin
         if (u == 0) q0.push_back(e);
         else q3.push_back(e);
      end
      while (!((u == 0) ? r0 : r3) && n < 40) begin
         @(negedge aclk);
         n++;
      end
      if (!((u == 0) ? r0 : r3)) begin
         checks++;
         failures++;
         $display("FAIL ready_wait unit=%0d actual=0 required=1", u);
      end
      @(negedge aclk);
      if (u == 0) begin v0 = 1'b0; clr0 = 1'b0; end
      else begin v3 = 1'b0; clr3 = 1'b0; end
   endtask

   task automatic clear0();
      @(negedge aclk);
      clr0 = 1'b1;
      @(negedge aclk);
      clr0 = 1'b0;
      chk("clr_beat_count", 32'(bc0), 32'd0);
      chk("clr_err_count", 32'(ec0), 32'd0);
      chk("clr_last_interval", li0, 32'd0);
      chk("clr_timeout", 32'(to0), 32'd0);
   endtask

   // Track counted accepts two edges deep: statistics show one edge after acceptance
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         a0_d <= 1'b0; a0_d1 <= 1'b0; a3_d <= 1'b0; a3_d1 <= 1'b0;
      end else begin
         a0_d  <= v0 && r0 && !clr0;
         a0_d1 <= a0_d && !clr0;
         a3_d  <= v3 && r3 && !clr3;
         a3_d1 <= a3_d && !clr3;
      end
   end

   always @(negedge aclk) begin
      if (a0_d1) begin
         if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb0_unexpected_beat actual=%0d required=none", bc0);
         end else begin
            m0 = q0.pop_front();
            chk("d0_beat_count", 32'(bc0), 32'(m0.bc));
            chk("d0_err_count", 32'(ec0), 32'(m0.ec));
            chk("d0_error", 32'(er0), 32'(m0.er));
            chk("d0_last_interval", li0, m0.li);
         end
      end
      if (a3_d1) begin
         if (q3.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb3_unexpected_beat actual=%0d required=none", bc3);
         end else begin
            m3 = q3.pop_front();
            chk("d3_beat_count", 32'(bc3), 32'(m3.bc));
            chk("d3_err_count", 32'(ec3), 32'(m3.ec));
            chk("d3_error", 32'(er3), 32'(m3.er));
            chk("d3_last_interval", li3, m3.li);
         end
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      #1 aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      chk("rst_ready0", 32'(r0), 32'd0);
      chk("rst_ready3", 32'(r3), 32'd0);
      chk("rst_beat_count", 32'(bc0), 32'd0);
      chk("rst_err_count", 32'(ec0), 32'd0);
      chk("rst_error", 32'(er0), 32'd0);
      chk("rst_timeout", 32'(to0), 32'd0);
      chk("rst_last_interval", li0, 32'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("rel_ready0", 32'(r0), 32'd1);
      chk("rel_ready3", 32'(r3), 32'd1);

      // Back-to-back 00,01,00,01 with no backpressure
      send(0, 8'h00, 1'b0, 1'b1, mk(1, 0, 1'b0, 0), lows); chk("d0_ready_low", lows, 0);
      send(0, 8'h01, 1'b0, 1'b1, mk(2, 0, 1'b0, 1), lows); chk("d0_ready_low", lows, 0);
      send(0, 8'h00, 1'b0, 1'b1, mk(3, 0, 1'b0, 1), lows); chk("d0_ready_low", lows, 0);
      send(0, 8'h01, 1'b0, 1'b1, mk(4, 0, 1'b0, 1), lows); chk("d0_ready_low", lows, 0);

      // 00,01,01,00: only the repeated 01 is wrong
      clear0();
      send(0, 8'h00, 1'b0, 1'b1, mk(1, 0, 1'b0, 0), lows);
      send(0, 8'h01, 1'b0, 1'b1, mk(2, 0, 1'b0, 1), lows);
      send(0, 8'h01, 1'b0, 1'b1, mk(3, 1, 1'b1, 1), lows);
      send(0, 8'h00, 1'b0, 1'b1, mk(4, 1, 1'b1, 1), lows);

      // 300 x 0x55 after reference 0x00: error count saturates
      clear0();
      send(0, 8'h00, 1'b0, 1'b1, mk(1, 0, 1'b0, 0), lows);
      for (int i = 1; i <= 300; i++) begin
         send(0, 8'h55, 1'b0, 1'b1, mk(1 + i, (i > 255) ? 255 : i, 1'b1, 1), lows);
      end

      // Stall: timeout rises 10 edges after the accept, next beat clears it
      clear0();
      send(0, 8'h00, 1'b0, 1'b1, mk(1, 0, 1'b0, 0), lows);
      repeat (9) @(negedge aclk);
      chk("timeout_before", 32'(to0), 32'd0);
      @(negedge aclk);
      chk("timeout_at_10", 32'(to0), 32'd1);
      @(negedge aclk);
      send(0, 8'h01, 1'b0, 1'b1, mk(2, 0, 1'b0, 12), lows);
      chk("timeout_cleared", 32'(to0), 32'd0);
      send(0, 8'h01, 1'b0, 1'b1, mk(3, 1, 1'b1, 1), lows);

      // Clear on an accepting edge: that beat is ignored, the next is the reference
      @(negedge aclk);
      send(0, 8'h01, 1'b1, 1'b0, mk(0, 0, 1'b0, 0), lows);
      chk("clracc_beat_count", 32'(bc0), 32'd0);
      chk("clracc_err_count", 32'(ec0), 32'd0);
      chk("clracc_error", 32'(er0), 32'd0);
      chk("clracc_last_interval", li0, 32'd0);
      chk("clracc_ready", 32'(r0), 32'd1);
      send(0, 8'h00, 1'b0, 1'b1, mk(1, 0, 1'b0, 0), lows);
      send(0, 8'h01, 1'b0, 1'b1, mk(2, 0, 1'b0, 1), lows);

      // Reference beat with a non-zero upper nibble counts one error
      clear0();
      send(0, 8'hF0, 1'b0, 1'b1, mk(1, 1, 1'b1, 0), lows);
      send(0, 8'h01, 1'b0, 1'b1, mk(2, 1, 1'b1, 1), lows);

      // READY_DELAY=3: three low cycles after each accept, interval 4
      send(3, 8'h00, 1'b0, 1'b1, mk(1, 0, 1'b0, 0), lows); chk("d3_first_low", lows, 0);
      send(3, 8'h01, 1'b0, 1'b1, mk(2, 0, 1'b0, 4), lows); chk("d3_ready_low", lows, 3);
      send(3, 8'h00, 1'b0, 1'b1, mk(3, 0, 1'b0, 4), lows); chk("d3_ready_low", lows, 3);
      send(3, 8'h01, 1'b0, 1'b1, mk(4, 0, 1'b0, 4), lows); chk("d3_ready_low", lows, 3);
      send(3, 8'h00, 1'b0, 1'b1, mk(5, 0, 1'b0, 4), lows); chk("d3_ready_low", lows, 3);

      // Asynchronous reset in the middle of a hold
      @(negedge aclk);
      #1 aresetn = 1'b0;
      #1;
      chk("midrst_ready", 32'(r3), 32'd0);
      chk("midrst_beat_count", 32'(bc3), 32'd0);
      chk("midrst_err_count", 32'(ec3), 32'd0);
      chk("midrst_last_interval", li3, 32'd0);
      chk("midrst_d0_beat_count", 32'(bc0), 32'd0);
      chk("midrst_d0_error", 32'(er0), 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      send(3, 8'h00, 1'b0, 1'b1, mk(1, 0, 1'b0, 0), lows);
      send(3, 8'h01, 1'b0, 1'b1, mk(2, 0, 1'b0, 4), lows); chk("d3_post_rst_low", lows, 3);

      repeat (3) @(negedge aclk);
      chk("sb0_drained", q0.size(), 32'd0);
      chk("sb3_drained", q3.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
